alu_issue: RTL and testbench

Single-issue decode, operand-fetch and writeback stage that drives the `alu` block. It accepts RV32I register-register (OP) and register-immediate (OP-IMM) instruction words over a valid/ready handshake and owns the 32×32 integer register file. It presents `funct3`, the funct7 bit and the operand values to the ALU, captures the ALU's registered result one cycle later, and writes it back to `rd`.

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue.sv | 142 ++++++++++++++
 tb/tb_alu_issue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Bus between the issue stage and its surroundings: instruction handshake,
// ALU operand/result lines, retire/illegal reporting and the debug read port.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [2:0]      alu_funct3;
    logic            alu_funct7;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [XLEN-1:0] alu_rd;
    logic            retire_valid;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_data;
    logic            illegal;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    // Upstream/environment side: supplies instructions, the ALU result and debug index.
    modport master (
        output instr_valid, instr, alu_rd, dbg_addr,
        input  instr_ready, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
               retire_valid, retire_rd, retire_data, illegal, dbg_data
    );

    // Issue stage side.
    modport slave (
        input  instr_valid, instr, alu_rd, dbg_addr,
        output instr_ready, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
               retire_valid, retire_rd, retire_data, illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue.sv
// Single-issue decode / operand fetch / writeback stage for RV32I OP and
// OP-IMM instructions. Owns the 32-entry register file and drives an external
// ALU whose result arrives one cycle after the operands are presented.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_regs [32];
    logic            r_illegal;
    logic [2:0]      r_funct3;
    logic            r_funct7;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_rd;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_legal;
    logic            w_f7_bit;
    logic [XLEN-1:0] w_op2;
    logic            w_ready;
    logic            w_accept;
    logic            w_wb;

    assign w_opcode  = bus.instr[6:0];
    assign w_f3      = bus.instr[14:12];
    assign w_f7      = bus.instr[31:25];
    assign w_rs1_idx = bus.instr[19:15];
    assign w_rs2_idx = bus.instr[24:20];
    assign w_rs1_val = (w_rs1_idx == 5'd0) ? '0 : r_regs[w_rs1_idx];
    assign w_rs2_val = (w_rs2_idx == 5'd0) ? '0 : r_regs[w_rs2_idx];

    // The cycle after an illegal word is still busy (illegal pulse), so ready stays low then.
    assign w_ready  = (r_state == S_IDLE) && !r_illegal;
    assign w_accept = bus.instr_valid && w_ready;
    assign w_wb     = (r_state == S_WB);

    // Decode legality, ALU funct7 bit and the second operand (shift amounts are 5 bits wide).
    always_comb begin
        w_legal  = 1'b0;
        w_f7_bit = 1'b0;
        w_op2    = w_rs2_val;
        case (w_opcode)
            OPC_OP: begin
                w_legal  = (w_f7 == 7'b0000000) ||
                           ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_f7_bit = bus.instr[30];
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101))
                    w_op2 = {{(XLEN-5){1'b0}}, w_rs2_val[4:0]};
            end
            OPC_OP_IMM: begin
                w_op2 = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
                case (w_f3)
                    3'b001: begin
                        w_legal = (w_f7 == 7'b0000000);
                        w_op2   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
                    end
                    3'b101: begin
                        w_legal  = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                        w_op2    = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
                        w_f7_bit = bus.instr[30];
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state logic: legal words run ISSUE then WB; illegal words stay in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_legal) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Capture decoded operands on a legal accept; they hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_funct3  <= '0;
            r_funct7  <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_funct3 <= w_f3;
                r_funct7 <= w_f7_bit;
                r_rs1    <= w_rs1_val;
                r_rs2    <= w_op2;
                r_rd     <= bus.instr[11:7];
            end
        end
    end

    // Register file: written from the ALU result in WB; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_wb && (r_rd != 5'd0)) begin
            r_regs[r_rd] <= bus.alu_rd;
        end
    end

    assign bus.instr_ready  = w_ready;
    assign bus.alu_funct3   = r_funct3;
    assign bus.alu_funct7   = r_funct7;
    assign bus.alu_rs1      = r_rs1;
    assign bus.alu_rs2      = r_rs2;
    assign bus.illegal      = r_illegal;
    assign bus.retire_valid = w_wb;
    assign bus.retire_rd    = w_wb ? r_rd : 5'd0;
    assign bus.retire_data  = w_wb ? bus.alu_rd : '0;
    assign bus.dbg_data     = (bus.dbg_addr == 5'd0) ? '0 : r_regs[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a transaction-level model predicts decode, ALU result,
// retire/illegal timing and register contents; one compare process checks
// the DUT every cycle, and directed literal checks pin the model.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus ();
    alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state.
    logic [31:0] m_regs [32];
    int          acc_cyc   = -10;
    int          next_free = 0;
    int          exp_iss   = -1;
    int          exp_wb    = -1;
    int          exp_ill   = -1;
    logic [2:0]  pend_f3, cur_f3;
    logic        pend_f7, cur_f7;
    logic [31:0] pend_a, pend_b, cur_a, cur_b;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          sweep_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return f7 ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Bench ALU: registered result, one cycle after the operands.
    initial bus.alu_rd = '0;
    always @(posedge clk) bus.alu_rd <= alu_ref(bus.alu_funct3, bus.alu_funct7, bus.alu_rs1, bus.alu_rs2);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_iss = -1; exp_wb = -1; exp_ill = -1;
        acc_cyc = -10; next_free = 0;
        cur_f3 = '0; cur_f7 = 1'b0; cur_a = '0; cur_b = '0;
    endtask

    // Decode per the instruction-set rules, reading the model register file.
    task automatic model_decode(input logic [31:0] w, output bit legal, output logic [2:0] f3,
                                output logic f7, output logic [31:0] a, output logic [31:0] b);
        logic [6:0]  opc = w[6:0];
        logic [6:0]  fu7 = w[31:25];
        logic [31:0] v2  = m_regs[w[24:20]];
        bit          shift;
        f3 = w[14:12];
        a  = m_regs[w[19:15]];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        legal = 1'b0; f7 = 1'b0; b = v2;
        if (opc == 7'h33) begin
            legal = (fu7 == 7'h00) || (fu7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            f7 = w[30];
            b = shift ? {27'd0, v2[4:0]} : v2;
        end else if (opc == 7'h13) begin
            legal = (f3 == 3'd1) ? (fu7 == 7'h00) :
                    (f3 == 3'd5) ? (fu7 == 7'h00 || fu7 == 7'h20) : 1'b1;
            f7 = (f3 == 3'd5) ? w[30] : 1'b0;
            b = shift ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
        end
    endtask

    task automatic wait_idle();
        while (cyc < next_free) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one word in its accept cycle N; returns at N+1 (+1ns). With hold,
    // instr_valid stays high with a junk word until the stage is free again.
    task automatic send(input logic [31:0] w, input bit hold);
        bit legal;
        wait_idle();
        model_decode(w, legal, pend_f3, pend_f7, pend_a, pend_b);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        acc_cyc = cyc;
        if (legal) begin
            exp_iss = cyc + 1; exp_wb = cyc + 2; next_free = cyc + 3;
            exp_rd = w[11:7];
            exp_data = alu_ref(pend_f3, pend_f7, pend_a, pend_b);
        end else begin
            exp_ill = cyc + 1; next_free = cyc + 2;
        end
        $display("txn cyc=%0d instr=%h legal=%0d rd=%0d expect=%h", cyc, w, legal, w[11:7],
                 legal ? alu_ref(pend_f3, pend_f7, pend_a, pend_b) : 32'd0);
        @(posedge clk); #1;
        if (hold) bus.instr = 32'h00100393;
        else bus.instr_valid = 1'b0;
        if (hold) begin
            wait_idle();
            bus.instr_valid = 1'b0;
        end
    endtask

    task automatic dbg_lit(input logic [4:0] a, input logic [31:0] v, input string nm);
        sweep_en = 1'b0;
        bus.dbg_addr = a;
        #1;
        chk(nm, bus.dbg_data, v);
        sweep_en = 1'b1;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (cyc == exp_iss) begin
            cur_f3 = pend_f3; cur_f7 = pend_f7; cur_a = pend_a; cur_b = pend_b;
        end
        chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, !(cyc > acc_cyc && cyc < next_free)});
        chk("illegal", {31'd0, bus.illegal}, {31'd0, cyc == exp_ill});
        chk("retire_valid", {31'd0, bus.retire_valid}, {31'd0, cyc == exp_wb});
        chk("alu_funct3", {29'd0, bus.alu_funct3}, {29'd0, cur_f3});
        chk("alu_funct7", {31'd0, bus.alu_funct7}, {31'd0, cur_f7});
        chk("alu_rs1", bus.alu_rs1, cur_a);
        chk("alu_rs2", bus.alu_rs2, cur_b);
        chk("dbg_data", bus.dbg_data, (bus.dbg_addr == 5'd0) ? 32'd0 : m_regs[bus.dbg_addr]);
        if (cyc == exp_wb) begin
            chk("retire_rd", {27'd0, bus.retire_rd}, {27'd0, exp_rd});
            chk("retire_data", bus.retire_data, exp_data);
            if (exp_rd != 5'd0) m_regs[exp_rd] = exp_data;
        end
        if (sweep_en) bus.dbg_addr = bus.dbg_addr + 5'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.dbg_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) dbg_lit(5'(i), 32'd0, "reset_reg");

        // ADDI x1,x0,5
        send(32'h00500093, 1'b0);
        chk("lit_addi_f3", {29'd0, bus.alu_funct3}, 32'd0);
        chk("lit_addi_f7", {31'd0, bus.alu_funct7}, 32'd0);
        chk("lit_addi_rs1", bus.alu_rs1, 32'd0);
        chk("lit_addi_rs2", bus.alu_rs2, 32'd5);
        @(posedge clk); #1;
        chk("lit_ret_valid", {31'd0, bus.retire_valid}, 32'd1);
        chk("lit_ret_rd", {27'd0, bus.retire_rd}, 32'd1);
        chk("lit_ret_data", bus.retire_data, 32'd5);
        wait_idle();
        dbg_lit(5'd1, 32'd5, "lit_x1");

        // ADDI x2,x0,-3
        send(32'hFFD00113, 1'b0);
        chk("lit_addim_rs2", bus.alu_rs2, 32'hFFFFFFFD);
        chk("lit_addim_f7", {31'd0, bus.alu_funct7}, 32'd0);
        // SUB x3,x1,x2
        send(32'h402081B3, 1'b0);
        chk("lit_sub_f7", {31'd0, bus.alu_funct7}, 32'd1);
        chk("lit_sub_rs1", bus.alu_rs1, 32'd5);
        chk("lit_sub_rs2", bus.alu_rs2, 32'hFFFFFFFD);
        wait_idle();
        dbg_lit(5'd3, 32'd8, "lit_x3");

        // SRAI x4,x2,1
        send(32'h40115213, 1'b0);
        chk("lit_srai_f3", {29'd0, bus.alu_funct3}, 32'd5);
        chk("lit_srai_f7", {31'd0, bus.alu_funct7}, 32'd1);
        chk("lit_srai_rs2", bus.alu_rs2, 32'd1);
        wait_idle();
        dbg_lit(5'd4, 32'hFFFFFFFE, "lit_x4");

        // ADDI x5,x0,33 then SLL x6,x1,x5
        send(32'h02100293, 1'b0);
        send(32'h00509333, 1'b0);
        chk("lit_sll_rs2", bus.alu_rs2, 32'd1);
        wait_idle();
        dbg_lit(5'd6, 32'd10, "lit_x6");

        // SRL x8,x2,x5 ; ADDI x1,x1,0x400 (imm[10]=1 must stay ADD)
        send(32'h00515433, 1'b0);
        send(32'h40008093, 1'b0);
        chk("lit_addi400_f7", {31'd0, bus.alu_funct7}, 32'd0);
        wait_idle();
        dbg_lit(5'd8, 32'h7FFFFFFE, "lit_x8");
        dbg_lit(5'd1, 32'h00000405, "lit_x1b");

        // Illegal words, including SLLI with nonzero funct7.
        send(32'h00000073, 1'b0);
        chk("lit_ill_pulse", {31'd0, bus.illegal}, 32'd1);
        send(32'h0000006F, 1'b0);
        send(32'h02208033, 1'b0);
        send(32'h40109213, 1'b0);
        wait_idle();
        dbg_lit(5'd4, 32'hFFFFFFFE, "lit_x4_kept");

        // ADDI x0,x0,7 retires but writes nothing.
        send(32'h00700013, 1'b0);
        @(posedge clk); #1;
        chk("lit_x0_ret", {27'd0, bus.retire_rd}, 32'd0);
        wait_idle();
        dbg_lit(5'd0, 32'd0, "lit_x0");

        // instr_valid held high through ISSUE/WB with a junk ADDI x7.
        send(32'h00100013, 1'b1);
        repeat (2) @(posedge clk);
        #1 dbg_lit(5'd7, 32'd0, "lit_x7_ignored");

        // Reset during ISSUE.
        send(32'h00900493, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) dbg_lit(5'(i), 32'd0, "rst_reg");

        // Works again after reset.
        send(32'h00500093, 1'b0);
        wait_idle();
        dbg_lit(5'd1, 32'd5, "lit_x1_after_rst");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
